// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button pulses -> run/stop/clear controls, lap snapshot and display select.
// Controls change one cycle after a button pulse. Inputs are never stalled; overlapping pulses resolve by fixed priority.
module stopwatch_ctrl #(
  parameter int LAP_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_btn_run_stop,
  input  logic                 i_btn_clear,
  input  logic                 i_btn_lap,
  input  logic [6:0]           i_msec,
  input  logic [5:0]           i_sec,
  input  logic [5:0]           i_min,
  input  logic [4:0]           i_hour,
  output logic                 o_run,
  output logic                 o_stop,
  output logic                 o_clear,
  output logic [6:0]           o_disp_msec,
  output logic [5:0]           o_disp_sec,
  output logic [5:0]           o_disp_min,
  output logic [4:0]           o_disp_hour,
  output logic                 o_lap_hold,
  output logic [LAP_CNT_W-1:0] o_lap_cnt,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_lap_action;
  logic                   w_enter_clear;

  logic [6:0]             r_lap_msec;
  logic [5:0]             r_lap_sec;
  logic [5:0]             r_lap_min;
  logic [4:0]             r_lap_hour;
  logic                   r_lap_hold;
  logic [LAP_CNT_W-1:0]   r_lap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_lap_action = 1'b0;
    unique case (r_state)
      ST_STOP: begin
        if (i_btn_run_stop) begin
          w_next_state = ST_RUN;
        end else if (i_btn_clear) begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_RUN: begin
        // run_stop wins over lap; clear is meaningless while running
        if (i_btn_run_stop) begin
          w_next_state = ST_STOP;
        end else if (i_btn_lap) begin
          w_lap_action = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_next_state = ST_STOP;
      end
      default: begin
        w_next_state = ST_STOP;
      end
    endcase
  end

  assign w_enter_clear = (w_next_state == ST_CLEAR) && (r_state != ST_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lap_msec <= '0;
      r_lap_sec  <= '0;
      r_lap_min  <= '0;
      r_lap_hour <= '0;
      r_lap_hold <= 1'b0;
      r_lap_cnt  <= '0;
    end else if (w_enter_clear) begin
      r_lap_msec <= '0;
      r_lap_sec  <= '0;
      r_lap_min  <= '0;
      r_lap_hour <= '0;
      r_lap_hold <= 1'b0;
      r_lap_cnt  <= '0;
    end else if (w_lap_action) begin
      if (r_lap_hold) begin
        r_lap_hold <= 1'b0;
      end else begin
        r_lap_msec <= i_msec;
        r_lap_sec  <= i_sec;
        r_lap_min  <= i_min;
        r_lap_hour <= i_hour;
        r_lap_hold <= 1'b1;
        if (r_lap_cnt != {LAP_CNT_W{1'b1}}) begin
          r_lap_cnt <= r_lap_cnt + 1'b1;
        end
      end
    end
  end

  assign o_run   = (r_state == ST_RUN);
  assign o_stop  = (r_state == ST_STOP);
  assign o_clear = (r_state == ST_CLEAR);
  assign o_state = r_state;

  assign o_lap_hold = r_lap_hold;
  assign o_lap_cnt  = r_lap_cnt;

  assign o_disp_msec = r_lap_hold ? r_lap_msec : i_msec;
  assign o_disp_sec  = r_lap_hold ? r_lap_sec  : i_sec;
  assign o_disp_min  = r_lap_hold ? r_lap_min  : i_min;
  assign o_disp_hour = r_lap_hold ? r_lap_hour : i_hour;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int LAP_CNT_W = 4;
  localparam int CNT_MAX   = (1 << LAP_CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic                 i_btn_run_stop;
  logic                 i_btn_clear;
  logic                 i_btn_lap;
  logic [6:0]           i_msec;
  logic [5:0]           i_sec;
  logic [5:0]           i_min;
  logic [4:0]           i_hour;
  logic                 o_run;
  logic                 o_stop;
  logic                 o_clear;
  logic [6:0]           o_disp_msec;
  logic [5:0]           o_disp_sec;
  logic [5:0]           o_disp_min;
  logic [4:0]           o_disp_hour;
  logic                 o_lap_hold;
  logic [LAP_CNT_W-1:0] o_lap_cnt;
  logic [1:0]           o_state;

  stopwatch_ctrl #(.LAP_CNT_W(LAP_CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_btn_run_stop (i_btn_run_stop),
    .i_btn_clear    (i_btn_clear),
    .i_btn_lap      (i_btn_lap),
    .i_msec         (i_msec),
    .i_sec          (i_sec),
    .i_min          (i_min),
    .i_hour         (i_hour),
    .o_run          (o_run),
    .o_stop         (o_stop),
    .o_clear        (o_clear),
    .o_disp_msec    (o_disp_msec),
    .o_disp_sec     (o_disp_sec),
    .o_disp_min     (o_disp_min),
    .o_disp_hour    (o_disp_hour),
    .o_lap_hold     (o_lap_hold),
    .o_lap_cnt      (o_lap_cnt),
    .o_state        (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: 0=STOP 1=RUN 2=CLEAR, lap snapshot packed {msec,sec,min,hour}
  int        m_state;
  bit        m_hold;
  int        m_cnt;
  bit [23:0] m_lap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_hold  = 0;
    m_cnt   = 0;
    m_lap   = '0;
  endtask

  task automatic model_step(input bit rs, input bit cl, input bit lp);
    if (m_state == 2) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (rs) m_state = 1;
      else if (cl) begin
        m_state = 2;
        m_hold  = 0;
        m_cnt   = 0;
        m_lap   = '0;
      end
    end else begin
      if (rs) m_state = 0;
      else if (lp) begin
        if (m_hold) m_hold = 0;
        else begin
          m_lap  = {i_msec, i_sec, i_min, i_hour};
          m_hold = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit [23:0] exp_disp;
    exp_disp = m_hold ? m_lap : {i_msec, i_sec, i_min, i_hour};
    check("state",    32'(o_state),    32'(m_state));
    check("run",      32'(o_run),      32'(m_state == 1));
    check("stop",     32'(o_stop),     32'(m_state == 0));
    check("clear",    32'(o_clear),    32'(m_state == 2));
    check("onehot",   32'(int'(o_run) + int'(o_stop) + int'(o_clear)), 32'd1);
    check("lap_hold", 32'(o_lap_hold), 32'(m_hold));
    check("lap_cnt",  32'(o_lap_cnt),  32'(m_cnt));
    check("disp",     32'({o_disp_msec, o_disp_sec, o_disp_min, o_disp_hour}), 32'(exp_disp));
  endtask

  task automatic rand_live();
    i_msec = 7'($urandom_range(0, 99));
    i_sec  = 6'($urandom_range(0, 59));
    i_min  = 6'($urandom_range(0, 59));
    i_hour = 5'($urandom_range(0, 23));
  endtask

  // one clock cycle: drive pulses, clock, advance model, then compare away from the edge
  task automatic cyc(input bit rs, input bit cl, input bit lp, input bit rnd);
    if (rnd) rand_live();
    i_btn_run_stop = rs;
    i_btn_clear    = cl;
    i_btn_lap      = lp;
    @(posedge clk);
    model_step(rs, cl, lp);
    #1;
    i_btn_run_stop = 1'b0;
    i_btn_clear    = 1'b0;
    i_btn_lap      = 1'b0;
    compare_all();
  endtask

  task automatic go_stop();
    for (int k = 0; k < 4 && m_state != 0; k++) begin
      if (m_state == 1) cyc(1, 0, 0, 1);
      else cyc(0, 0, 0, 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    i_btn_run_stop = 1'b0;
    i_btn_clear    = 1'b0;
    i_btn_lap      = 1'b0;
    rand_live();
    model_reset();

    // reset held for three cycles
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      rand_live();
      #1;
      compare_all();
    end
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    check("rst_stop_lit",  32'(o_stop),    32'd1);
    check("rst_state_lit", 32'(o_state),   32'd0);
    check("rst_cnt_lit",   32'(o_lap_cnt), 32'd0);

    // start, run 50 cycles, ignored clear, stop
    cyc(1, 0, 0, 1);
    check("start_run_lit", 32'(o_run), 32'd1);
    for (int k = 0; k < 48; k++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    check("clear_in_run_lit", 32'(o_state), 32'd1);
    cyc(1, 0, 0, 1);
    check("stop_lit", 32'(o_stop), 32'd1);

    // clear from STOP lasts exactly one cycle
    cyc(0, 1, 0, 1);
    check("clear_pulse_lit", 32'(o_clear), 32'd1);
    cyc(0, 0, 0, 1);
    check("clear_done_lit", 32'(o_clear), 32'd0);

    // lap capture with a known time, then live inputs keep moving
    cyc(1, 0, 0, 1);
    i_msec = 7'd42; i_sec = 6'd17; i_min = 6'd3; i_hour = 5'd1;
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1);
    check("lap_disp_lit", 32'({o_disp_msec, o_disp_sec, o_disp_min, o_disp_hour}),
          32'({7'd42, 6'd17, 6'd3, 5'd1}));
    check("lap_cnt1_lit", 32'(o_lap_cnt), 32'd1);
    cyc(0, 0, 1, 1);
    check("lap_release_lit", 32'(o_lap_hold), 32'd0);
    check("lap_cnt_stay_lit", 32'(o_lap_cnt), 32'd1);
    check("live_disp_lit", 32'(o_disp_msec), 32'(i_msec));

    // second capture, stop, clear
    cyc(0, 0, 1, 1);
    check("lap_cnt2_lit", 32'(o_lap_cnt), 32'd2);
    cyc(1, 0, 0, 1);
    check("hold_across_stop_lit", 32'(o_lap_hold), 32'd1);
    cyc(0, 1, 0, 1);
    check("clr_cnt_lit",  32'(o_lap_cnt),  32'd0);
    check("clr_hold_lit", 32'(o_lap_hold), 32'd0);
    cyc(0, 0, 0, 1);

    // simultaneous pulses
    cyc(1, 1, 0, 1);
    check("sim_stop_lit", 32'(o_state), 32'd1);
    cyc(0, 0, 0, 1);
    check("sim_noclr_lit", 32'(o_clear), 32'd0);
    cyc(1, 0, 1, 1);
    check("sim_run_lit",   32'(o_state),    32'd0);
    check("sim_nocap_lit", 32'(o_lap_hold), 32'd0);

    // saturation: 20 capture/release pairs
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);
    end
    check("sat_cnt_lit", 32'(o_lap_cnt), 32'd15);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 4) == 0), 1);
    end

    // asynchronous reset in the middle of CLEAR
    go_stop();
    cyc(0, 1, 0, 1);
    check("pre_arst_clear_lit", 32'(o_clear), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_clear_lit", 32'(o_clear), 32'd0);
    check("arst_stop_lit",  32'(o_stop),  32'd1);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    compare_all();
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 200; k++) begin
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0), 1);
    end

    // asynchronous reset mid-RUN
    if (m_state != 1) begin
      go_stop();
      cyc(1, 0, 0, 1);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_run_lit", 32'(o_run), 32'd0);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control unit for the stopwatch datapath. Turns debounced single-cycle button pulses (run/stop toggle, clear, lap) into the datapath's `run`, `stop` and `clear` controls. Captures lap snapshots of the live time and selects whether the display shows live or lapped time. It sits between the button debouncers and the stopwatch datapath/display mux in the stopwatch top level.

## Interface
Parameters:
- `LAP_CNT_W`, default 4: width of the saturating lap counter.

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset, asynchronous, active-low
- `i_btn_run_stop`  in  1  one-cycle pulse; toggles run/stop
- `i_btn_clear`  in  1  one-cycle pulse; clear request
- `i_btn_lap`  in  1  one-cycle pulse; lap capture/release
- `i_msec`  in  7  live datapath centiseconds, 0–99
- `i_sec`  in  6  live seconds, 0–59
- `i_min`  in  6  live minutes, 0–59
- `i_hour`  in  5  live hours, 0–23
- `o_run`  out  1  datapath run enable
- `o_stop`  out  1  datapath stop/hold
- `o_clear`  out  1  datapath synchronous clear, one cycle
- `o_disp_msec`, `o_disp_sec`, `o_disp_min`, `o_disp_hour`  out  7/6/6/5  time to display
- `o_lap_hold`  out  1  display currently frozen on lap snapshot
- `o_lap_cnt`  out  LAP_CNT_W  number of laps taken, saturating
- `o_state`  out  2  encoded state: STOP=0, RUN=1, CLEAR=2

## Operation
- The FSM has three states.
  - **STOP** (reset state):
    - run_stop pulse -> RUN
    - else clear pulse -> CLEAR
    - lap pulse ignored
  - **RUN**:
    - run_stop pulse -> STOP
    - clear pulse ignored, no state change
    - lap pulse, only if run_stop is not asserted the same cycle: handled as the lap action below
  - **CLEAR**: unconditional -> STOP after exactly one cycle. All button pulses in this cycle are ignored.
- Control outputs are decoded from the state register only; there is no combinational path from the buttons.
  - `o_run` = (state==RUN)
  - `o_stop` = (state==STOP)
  - `o_clear` = (state==CLEAR)
  - Exactly one of the three is high at any time.
- Lap action in RUN:
  - If `o_lap_hold`=0: capture `i_msec..i_hour` into the lap registers, set `o_lap_hold`=1, and increment `o_lap_cnt`. The counter saturates at 2^LAP_CNT_W−1.
  - If `o_lap_hold`=1: clear `o_lap_hold` and return to the live display. There is no capture and no count change.
- Lap hold persists across RUN->STOP and STOP->RUN transitions.
- Entering CLEAR zeroes the lap registers, `o_lap_hold` and `o_lap_cnt` at the same edge.
- Display mux (combinational): `o_disp_*` = `o_lap_hold` ? lap registers : live `i_*`.
- Simultaneous pulses:
  - In STOP, run_stop has priority over clear.
  - In RUN, run_stop has priority over lap, so lap is dropped.
  - Clear in RUN is always dropped.
- The block assumes single-cycle input pulses. A level held high is treated as a pulse every cycle, so run_stop held high toggles RUN/STOP every cycle. This is the debouncer's responsibility.

## Timing
- Reset (rst=0, asynchronous) forces all of the following immediately; release is synchronous to the next `clk` edge:
  - state=STOP, so `o_stop`=1, `o_run`=0, `o_clear`=0, `o_state`=0
  - lap registers=0, `o_lap_hold`=0, `o_lap_cnt`=0
  - `o_disp_*` follows live inputs
- Latency, button pulse to control output: 1 cycle. A pulse high during cycle N produces the new state and outputs after the rising edge ending cycle N.
- `o_clear` is high for exactly 1 cycle. The datapath sees the counters cleared one edge later.
- Lap capture samples `i_*` at the same edge the lap pulse is sampled. `o_disp_*` shows the frozen value from the following cycle.
- Reset asserted mid-CLEAR or mid-RUN: the block returns to STOP immediately, with no residual `o_clear`.

## Test plan
- **Reset:** assert rst=0 for 3 cycles, release -> `o_stop`=1, `o_run`=0, `o_clear`=0, `o_state`=0, `o_lap_cnt`=0, `o_disp_*`=`i_*`.
- **Start/stop:** run_stop pulse -> `o_run`=1 next cycle. A second pulse 50 cycles later -> `o_stop`=1 next cycle. Clear pulse while RUN -> no change.
- **Clear:** in STOP, clear pulse -> `o_clear`=1 for exactly one cycle, then `o_stop`=1. Clear after 2 laps -> `o_lap_cnt`=0, `o_lap_hold`=0.
- **Lap:** in RUN with `i_msec`=42, `i_sec`=17, `i_min`=3, `i_hour`=1, pulse lap -> `o_disp_*`=42/17/3/1 frozen while `i_*` keep changing, `o_lap_cnt`=1. A second lap pulse -> display follows live, `o_lap_cnt` stays 1.
- **Simultaneous:**
  - STOP with run_stop+clear in the same cycle -> RUN, no `o_clear`.
  - RUN with run_stop+lap -> STOP, no capture, count unchanged.
- **Saturation/async reset:** 20 capture/release lap pairs -> `o_lap_cnt`=15. Drop rst during CLEAR -> `o_clear`=0 and `o_stop`=1 immediately, before the next clock edge.
